// File: rtl/div_by_divisor_seq.sv
// ---------------------------------------------------------------------------
// div_by_divisor_seq
//   Sequential restoring divider. It undoes multiply-by-constant scaling on
//   the RS datapath. The unsigned DIVIDEND_W-bit dividend is divided by the
//   unsigned DIVISOR_W-bit divisor. One quotient bit is retired per clock,
//   starting with the MSB.
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   start      request, accepted only when ready=1
//   dividend   unsigned dividend, sampled on the accepting edge
//   divisor    unsigned divisor, sampled on the accepting edge
//   ready      1 in IDLE/DONE (can accept start)
//   busy       1 while iterating (RUN)
//   done       one-cycle pulse in DONE, results valid
//   quotient   result quotient, held until the next DONE
//   remainder  result remainder, held until the next DONE
//   div_zero   last accepted divisor was 0, held with the results
//
// Timing: start accepted at edge k. Iterations happen on edges k+1..k+DIVIDEND_W.
// Edge k+DIVIDEND_W+1 publishes the results and enters DONE.
// ---------------------------------------------------------------------------
module div_by_divisor_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DIVIDEND_W-1:0]   sreg_reg;       // dividend shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]    dvsr_reg;
  logic [DIVISOR_W-1:0]    prem_reg;       // always < divisor, so DIVISOR_W bits suffice
  logic [DIVISOR_W-1:0]    dlow_reg;       // dividend low bits, remainder for divide-by-zero
  logic [CNT_W-1:0]        cnt_reg;
  logic [DIVIDEND_W-1:0]   quotient_reg;
  logic [DIVISOR_W-1:0]    remainder_reg;
  logic                    div_zero_reg;

  logic                    accept;
  logic                    iterating;
  logic                    finishing;
  logic [DIVISOR_W:0]      p;              // one bit wider so the compare cannot overflow
  logic [DIVISOR_W:0]      dvsr_ext;
  logic                    qbit;

  assign accept    = start && (state_reg != RUN);
  assign iterating = (state_reg == RUN) && (cnt_reg != LAST_CNT);
  assign finishing = (state_reg == RUN) && (cnt_reg == LAST_CNT);

  assign p        = {prem_reg, sreg_reg[DIVIDEND_W-1]};
  assign dvsr_ext = {1'b0, dvsr_reg};
  assign qbit     = (p >= dvsr_ext);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A start in DONE goes straight back to RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_CNT) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decodes, taken directly from the registered state
  always_comb begin
    ready = (state_reg != RUN);
    busy  = (state_reg == RUN);
    done  = (state_reg == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_reg      <= '0;
      dvsr_reg      <= '0;
      prem_reg      <= '0;
      dlow_reg      <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
    end else begin
      if (accept) begin
        sreg_reg <= dividend;
        dvsr_reg <= divisor;
        prem_reg <= '0;
        dlow_reg <= dividend[DIVISOR_W-1:0];
        cnt_reg  <= '0;
      end else if (iterating) begin
        // After subtraction the remainder is below divisor, so truncating is lossless
        prem_reg <= qbit ? DIVISOR_W'(p - dvsr_ext) : p[DIVISOR_W-1:0];
        sreg_reg <= {sreg_reg[DIVIDEND_W-2:0], qbit};
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end

      if (finishing) begin
        if (dvsr_reg == '0) begin
          quotient_reg  <= '1;
          remainder_reg <= dlow_reg;
          div_zero_reg  <= 1'b1;
        end else begin
          quotient_reg  <= sreg_reg;
          remainder_reg <= prem_reg;
          div_zero_reg  <= 1'b0;
        end
      end
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div_by_divisor_seq.sv
// ---------------------------------------------------------------------------
// tb_div_by_divisor_seq
//   Scoreboard bench for div_by_divisor_seq. The driver pushes the expected
//   result when a start is accepted. The monitor pops and compares on every
//   done pulse, and it also checks the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_div_by_divisor_seq;

  localparam int DW = 16;
  localparam int VW = 10;
  localparam int LAT = DW + 1;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   lat_q[$];
  exp_t last_exp;
  logic prev_done = 1'b0;

  div_by_divisor_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .ready(ready), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a[VW-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = DW'(a / DW'(b));
      e.r  = VW'(a % DW'(b));
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest expected result
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      lat_q.delete();
      prev_done = 1'b0;
    end else begin
      if (done) begin
        exp_t e;
        int   k;
        if (prev_done) chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_zero", 32'(div_zero), 32'(e.dz));
        end
        if (lat_q.size() != 0) begin
          k = lat_q.pop_front();
          chk("latency", 32'(cyc - k), 32'(LAT));
        end
        $display("done: q=%0d r=%0d dz=%0d at cycle %0d", quotient, remainder, div_zero, cyc);
      end
      prev_done = done;
      if (start && ready) lat_q.push_back(cyc + 1);
    end
  end

  // Driver phase: #1 after a rising edge
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int n = 0;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!ready) chk("issue_timeout", 32'(ready), 32'd1);
    else exp_q.push_back(model(a, b));
    last_exp = model(a, b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain_and_hold(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_hold_q"}, 32'(quotient), 32'(last_exp.q));
    chk({tag, "_hold_r"}, 32'(remainder), 32'(last_exp.r));
    chk({tag, "_hold_ready"}, 32'(ready), 32'd1);
    chk({tag, "_hold_done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(posedge clk); #1;

    // Directed vectors (expected values via model, hand-verified in comments)
    issue(16'd1000, 10'd32);   drain_and_hold("v1000_32");   // 31 r 8
    issue(16'd65535, 10'd1023); drain_and_hold("v65535_1023"); // 64 r 63
    issue(16'd5, 10'd7);       drain_and_hold("v5_7");       // 0 r 5
    issue(16'd1234, 10'd0);    drain_and_hold("v1234_0");    // FFFF r 0D2 dz
    chk("v1234_0_q", 32'(quotient), 32'h0000_FFFF);
    chk("v1234_0_r", 32'(remainder), 32'h0000_00D2);
    chk("v1000_32_const", 32'({model(16'd1000, 10'd32)}), 32'({16'd31, 10'd8, 1'b0}));

    // Start pulses while busy must be ignored
    issue(16'd100, 10'd10);    // 10 r 0
    repeat (5) begin
      chk("busy_during_run", 32'(busy), 32'd1);
      start = 1'b1;
      dividend = 16'd9;
      divisor = 10'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
    end
    drain_and_hold("ignore_start");

    // Back-to-back: start held through DONE
    start = 1'b1;
    dividend = 16'd500;
    divisor = 10'd7;           // 71 r 3
    @(negedge clk);
    exp_q.push_back(model(16'd500, 10'd7));
    @(posedge clk); #1;
    dividend = 16'd60000;
    divisor = 10'd999;         // 60 r 60
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_ready", 32'(ready), 32'd1);
    chk("b2b_done_with_ready", 32'(done), 32'd1);
    exp_q.push_back(model(16'd60000, 10'd999));
    last_exp = model(16'd60000, 10'd999);
    @(posedge clk); #1;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    start = 1'b0;
    drain_and_hold("b2b");

    // Boundary corners
    issue(16'd0, 10'd5);       drain_and_hold("v0_5");
    issue(16'd65535, 10'd1);   drain_and_hold("v65535_1");
    issue(16'd1023, 10'd1023); drain_and_hold("v1023_1023");
    issue(16'd0, 10'd0);       drain_and_hold("v0_0");
    issue(16'd65535, 10'd0);   drain_and_hold("v65535_0");

    // Random pairs, including the extreme divisors and dividends
    for (int i = 0; i < 200; i++) begin
      a = DW'($urandom_range(0, 65535));
      b = VW'($urandom_range(0, 1023));
      if (i % 10 == 0) b = 10'd1;
      if (i % 10 == 1) b = 10'd1023;
      if (i % 10 == 2) a = 16'd0;
      issue(a, b);
    end
    drain_and_hold("random");

    // Reset during RUN at iteration 8, with start also high on the reset edge
    issue(16'd1000, 10'd32);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    dividend = 16'd77;
    divisor = 10'd3;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
